// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue stage.
//   - RV32I/M opcode and funct7 constants used by the decoder
//   - issue_beat_t: one decoded beat as it is stored and presented to the ALU
//   - skid_state_t: occupancy of the 2-entry output skid buffer
// Optional feature macro used by the decoder: RV32M_EN.
package alu_issue_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic            wb_en;
        logic            illegal;
    } issue_beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational RV32I/M decode of one instruction
// into an issue_beat_t (ALU operands, opcode, funct3/funct7, rd, wb_en,
// illegal flag).
// Ports:
//   instr    in  32  instruction word
//   pc       in  32  instruction PC (AUIPC operand a)
//   rs1_val  in  32  value of register rs1
//   rs2_val  in  32  value of register rs2
//   beat     out     decoded beat
// Macro: RV32M_EN enables the funct7=0x01 (M extension) encodings of opcode 0x33.
import alu_issue_pkg::*;

module alu_issue_decode (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output issue_beat_t     beat
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] u_imm;
    logic            legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm  = {instr[31:12], 12'h000};

    always_comb begin
        beat         = '0;
        beat.opcode  = opcode;
        beat.rd      = instr[11:7];
        beat.wb_en   = 1'b1;
        legal        = 1'b1;

        case (opcode)
            OP_REG: begin
                beat.a      = rs1_val;
                beat.b      = rs2_val;
                beat.funct3 = f3;
                beat.funct7 = f7;
                case (f7)
                    F7_BASE:   legal = 1'b1;
                    F7_ALT:    legal = (f3 == 3'd0) || (f3 == 3'd5);
`ifdef RV32M_EN
                    // MULH/MULHSU/MULHU (funct3 1..3) are not supported.
                    F7_MULDIV: legal = !((f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3));
`else
                    F7_MULDIV: legal = 1'b0;
`endif
                    default:   legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                beat.a      = rs1_val;
                beat.funct3 = f3;
                if (f3 == 3'd1) begin
                    beat.b      = {27'd0, instr[24:20]};
                    beat.funct7 = f7;
                    legal       = (f7 == F7_BASE);
                end else if (f3 == 3'd5) begin
                    beat.b      = {27'd0, instr[24:20]};
                    beat.funct7 = f7;
                    legal       = (f7 == F7_BASE) || (f7 == F7_ALT);
                end else begin
                    beat.b = i_imm;
                end
            end
            OP_LUI: begin
                beat.b = u_imm;
            end
            OP_AUIPC: begin
                beat.a = pc;
                beat.b = u_imm;
            end
            OP_LOAD: begin
                beat.a      = rs1_val;
                beat.b      = i_imm;
                beat.funct3 = f3;
            end
            OP_STORE: begin
                beat.a      = rs1_val;
                beat.b      = s_imm;
                beat.funct3 = f3;
                beat.wb_en  = 1'b0;
            end
            OP_JALR: begin
                beat.a      = rs1_val;
                beat.b      = i_imm;
                beat.funct3 = f3;
                legal       = (f3 == 3'd0);
            end
            default: legal = 1'b0;
        endcase

        // An illegal beat keeps only opcode/rd; everything else is zeroed.
        if (!legal) begin
            beat.a      = '0;
            beat.b      = '0;
            beat.funct3 = '0;
            beat.funct7 = '0;
            beat.wb_en  = 1'b0;
        end
        beat.illegal = !legal;

        if (beat.rd == 5'd0) begin
            beat.wb_en = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an incoming instruction beat and presents it to
// the ALU through a 2-entry skid buffer (main + skid register).
// Handshake: a beat transfers on a rising edge where valid && ready on that
// side. in_ready is registered (state != FULL) and never depends on
// out_ready in the same cycle; out_* always come from the main register and
// hold stable while out_valid && !out_ready. flush empties the buffer and
// drops any beat accepted in the same cycle.
// Ports: clk, rst_n (async active-low), flush, in_valid/in_ready,
//   in_instr/in_pc/in_rs1_val/in_rs2_val, out_valid/out_ready, out_a, out_b,
//   out_opcode, out_funct3, out_funct7, out_rd, out_wb_en, out_illegal.
// Macro: RV32M_EN (see alu_issue_decode).
import alu_issue_pkg::*;

module alu_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [4:0]        out_rd,
    output logic              out_wb_en,
    output logic              out_illegal
);

    issue_beat_t dec_beat;
    issue_beat_t main_q;
    issue_beat_t skid_q;
    skid_state_t state;
    skid_state_t state_nx;
    logic        in_ready_q;
    logic        in_fire;
    logic        out_fire;
    logic        load_main;
    logic        main_from_skid;
    logic        load_skid;

    alu_issue_decode u_decode (
        .instr   (in_instr),
        .pc      (in_pc),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .beat    (dec_beat)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nx  = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_nx  = ST_FULL;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (out_fire) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nx       = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        // Flush wins: the register contents become don't-care once empty.
        if (flush) begin
            state_nx       = ST_EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != ST_FULL);
            if (load_main) begin
                main_q <= dec_beat;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_beat;
            end
        end
    end

    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_opcode  = main_q.opcode;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_rd      = main_q.rd;
    assign out_wb_en   = main_q.wb_en;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed + randomized bench for alu_issue_stage.
// Reference: an instruction-level decode function plus a queue holding the
// beats currently inside the stage (capacity 2).
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en),
        .out_illegal (out_illegal)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference decode, written from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [31:0] shamt;
        int          op;
        int          f3;
        int          f7;
        bit          legal;
        bit          m_en;
`ifdef RV32M_EN
        m_en = 1'b1;
`else
        m_en = 1'b0;
`endif
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        imm_i = $signed(ins) >>> 20;
        imm_s = (imm_i & ~32'h1F) | ((ins >> 7) & 32'h1F);
        imm_u = ins & 32'hFFFFF000;
        shamt = (ins >> 20) & 32'h1F;
        e     = '0;
        e.op  = ins[6:0];
        e.rd  = ins[11:7];
        legal = 1'b1;
        e.wb  = 1'b1;
        case (op)
            'h33: begin
                e.a = r1; e.b = r2; e.f3 = 3'(f3); e.f7 = 7'(f7);
                legal = (f7 == 0) || (f7 == 'h20 && f3 inside {0, 5}) ||
                        (m_en && f7 == 1 && f3 inside {0, 4, 5, 6, 7});
            end
            'h13: begin
                e.a = r1; e.f3 = 3'(f3);
                if (f3 == 1 || f3 == 5) begin
                    e.b = shamt; e.f7 = 7'(f7);
                    legal = (f7 == 0) || (f3 == 5 && f7 == 'h20);
                end else begin
                    e.b = imm_i;
                end
            end
            'h37: e.b = imm_u;
            'h17: begin e.a = pc; e.b = imm_u; end
            'h03: begin e.a = r1; e.b = imm_i; e.f3 = 3'(f3); end
            'h23: begin e.a = r1; e.b = imm_s; e.f3 = 3'(f3); e.wb = 1'b0; end
            'h67: begin e.a = r1; e.b = imm_i; e.f3 = 3'(f3); legal = (f3 == 0); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.a = 0; e.b = 0; e.f3 = 0; e.f7 = 0; e.wb = 1'b0;
        end
        e.ill = !legal;
        if (e.rd == 0) e.wb = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare DUT state against the reference queue (called away from edges).
    task automatic check_outputs();
        exp_t h;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("out_a", out_a, h.a);
            chk("out_b", out_b, h.b);
            chk("out_opcode", 32'(out_opcode), 32'(h.op));
            chk("out_rd", 32'(out_rd), 32'(h.rd));
            chk("out_wb_en", 32'(out_wb_en), 32'(h.wb));
            chk("out_illegal", 32'(out_illegal), 32'(h.ill));
            if (!h.ill) begin
                chk("out_funct3", 32'(out_funct3), 32'(h.f3));
                chk("out_funct7", 32'(out_funct7), 32'(h.f7));
            end
        end
    endtask

    // One clock: check, let the edge happen, then advance the reference.
    task automatic tick();
        bit   in_f;
        bit   out_f;
        exp_t d;
        check_outputs();
        in_f  = in_valid && (exp_q.size() < 2);
        out_f = out_ready && (exp_q.size() != 0);
        d     = model(in_instr, in_pc, in_rs1_val, in_rs2_val);
        @(posedge clk);
        #1;
        if (out_f) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_f) exp_q.push_back(d);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid   = v;
        in_instr   = ins;
        in_rs1_val = r1;
        in_rs2_val = r2;
        in_pc      = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_a"}, out_a, 32'd0);
        chk({tag, "_b"}, out_b, 32'd0);
        chk({tag, "_fields"}, {12'd0, out_opcode, out_funct3, out_funct7, out_rd},
            32'd0);
        chk({tag, "_flags"}, 32'({out_wb_en, out_illegal}), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          sel;
        ins = $urandom;
        sel = $urandom_range(0, 8);
        case (sel)
            0: ins[6:0] = 7'h33;
            1: begin ins[6:0] = 7'h33; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h01 : 7'h20; end
            2: begin ins[6:0] = 7'h33; ins[31:25] = 7'h00; end
            3: begin ins[6:0] = 7'h13; if ($urandom_range(0, 1) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            4: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
            5: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h23;
            6: begin ins[6:0] = 7'h67; if ($urandom_range(0, 1) != 0) ins[14:12] = 3'd0; end
            7: if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // ADD x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_op_rd", {out_opcode, out_funct3, out_funct7, out_rd, out_wb_en},
            {7'h33, 3'd0, 7'd0, 5'd3, 1'b1});
        tick();

        // ADDI x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'd0, 32'h1234);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("addi_a", out_a, 32'd0);
        chk("addi_b", out_b, 32'hFFFFFFFF);
        chk("addi_f7_wb", 32'({out_funct7, out_wb_en}), 32'({7'd0, 1'b1}));
        tick();

        // SRAI x5,x6,4
        drive(1'b1, 32'h40435293, 32'hDEAD0000, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("srai_b", out_b, 32'd4);
        chk("srai_f3_f7", 32'({out_funct3, out_funct7}), 32'({3'd5, 7'h20}));
        tick();

        // Back-pressure: three beats while the ALU stalls.
        out_ready = 1'b0;
        drive(1'b1, 32'h00110133, 32'd1, 32'd2);
        tick();
        drive(1'b1, 32'h00A00193, 32'd3, 32'd4);
        tick();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h12345237, 32'd5, 32'd6);
        tick();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) drive(1'b0, 32'd0, 32'd0, 32'd0);
        end
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Unsupported opcode.
        drive(1'b1, 32'hFFFFFFFF, 32'h11, 32'h22);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("ill_flag_wb", 32'({out_illegal, out_wb_en}), 32'({1'b1, 1'b0}));
        chk("ill_ab", out_a | out_b, 32'd0);
        chk("ill_op_rd", 32'({out_opcode, out_rd}), 32'({7'h7F, 5'd31}));
        tick();

        // MUL x3,x1,x2
        drive(1'b1, 32'h022081B3, 32'd9, 32'd9);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
`ifdef RV32M_EN
        chk("mul_legal", 32'({out_illegal, out_funct7, out_funct3, out_wb_en}),
            32'({1'b0, 7'h01, 3'd0, 1'b1}));
`else
        chk("mul_illegal", 32'({out_illegal, out_wb_en}), 32'({1'b1, 1'b0}));
`endif
        tick();

        // Flush while FULL, with an input offered in the flush cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h00208033, 32'd1, 32'd1);
        tick();
        drive(1'b1, 32'h00308033, 32'd2, 32'd2);
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h004080B3, 32'd3, 32'd3);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'd7, 32'd0);
        tick();
        drive(1'b1, 32'h00600313, 32'd8, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(1'b1, 32'h00700393, 32'd4, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("post_rst_latency", 32'(out_valid), 32'd1);
        chk("post_rst_b", out_b, 32'd7);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage that sits directly upstream of the ALU and produces its operation requests. It accepts a fetched 32-bit RV32I/M instruction with its PC and register-file operand values, then decodes opcode, funct3, funct7 and the immediate. It selects the ALU `a`/`b` operands, flags unsupported encodings, and presents the decoded beat through a 2-entry skid buffer with valid/ready handshakes on both sides.

## Interface
- `DATA_W`, 32: operand/PC width; only 32 supported.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all buffered beats.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: instruction PC.
- `in_rs1_val` in 32: value of register rs1 (instr[19:15]).
- `in_rs2_val` in 32: value of register rs2 (instr[24:20]).
- `out_valid` out 1: decoded beat valid.
- `out_ready` in 1: ALU/execute side accepts the beat.
- `out_a` out 32: ALU operand a.
- `out_b` out 32: ALU operand b.
- `out_opcode` out 7: instr[6:0].
- `out_funct3` out 3: decoded funct3.
- `out_funct7` out 7: decoded funct7.
- `out_rd` out 5: destination register.
- `out_wb_en` out 1: result must be written back.
- `out_illegal` out 1: unsupported encoding.

## Operation
- Decode per opcode; immediates are sign-extended:
  - 0x33: a=rs1, b=rs2, funct3=instr[14:12], funct7=instr[31:25].
    - Legal combinations: funct7 0x00 with any funct3; funct7 0x20 with funct3 0 or 5; funct7 0x01 with funct3 0, 4, 5, 6 or 7.
    - MULH/MULHSU/MULHU are illegal.
  - 0x13: a=rs1, b=I-imm.
    - funct3 1/5 (shifts): b=zero-extended instr[24:20], funct7=instr[31:25].
    - SLLI requires funct7 0x00. SRLI/SRAI require funct7 0x00 or 0x20.
    - Other funct3 values: funct7=0.
  - 0x37 LUI: a=0, b={instr[31:12],12'h0}.
  - 0x17 AUIPC: a=pc, b=U-imm.
  - 0x03 LOAD: a=rs1, b=I-imm.
  - 0x23 STORE: a=rs1, b=S-imm, wb_en=0.
  - 0x67 JALR: a=rs1, b=I-imm. funct3 must be 0.
  - For LUI/AUIPC/LOAD/STORE/JALR: funct7=0. funct3=0 for LUI/AUIPC, else instr[14:12].
- Any other opcode is illegal.
- Illegal beat:
  - out_illegal=1, out_wb_en=0, a=b=0.
  - opcode/rd are passed through.
  - The beat still transfers normally.
- out_wb_en=0 whenever rd==0.
- Skid buffer states: EMPTY, ONE (main reg valid), FULL (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept without output fire → FULL. Accept with output fire → ONE, main reloads. Output fire only → EMPTY.
  - FULL: output fire → ONE, main ← skid.
- out_* are always driven from the main register. Order is strictly preserved.

## Timing
- Transfer occurs when valid&ready on a rising edge.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready = (state != FULL). It is registered and independent of out_ready in the same cycle.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- flush:
  - Next state is EMPTY.
  - An input beat accepted in the flush cycle is dropped.
  - flush overrides a simultaneous output fire; the fire still counts for the ALU side.
- Reset (asynchronous, also mid-stream):
  - state EMPTY, out_valid=0, in_ready=1.
  - All data outputs 0, out_illegal=0, out_wb_en=0.

## Configuration
- `RV32M_EN` defined: funct7 0x01 under opcode 0x33 decodes as above.
- `RV32M_EN` undefined: every funct7 0x01 encoding is illegal.

## Structure
- Package `alu_issue_pkg`:
  - opcode constants (0x13, 0x33, 0x37, 0x17, 0x03, 0x23, 0x67).
  - funct7 constants (0x00, 0x20, 0x01).
  - packed typedef `issue_beat_t` (a, b, opcode, funct3, funct7, rd, wb_en, illegal).
- Sub-module `alu_issue_decode`: purely combinational instr/pc/rs values → `issue_beat_t`. The stage decodes before buffering and stores decoded beats.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle: out_valid, opcode 0x33, funct3 0, funct7 0, a=5, b=7, rd=3, wb_en=1.
- ADDI x1,x0,-1 (0xFFF00093), rs1=0 → a=0, b=0xFFFFFFFF, funct7 0, wb_en=1. SRAI x5,x6,4 (0x40435293) → b=4, funct3 5, funct7 0x20.
- out_ready=0, three back-to-back beats:
  - two accepted; in_ready=0 after the second; third held.
  - out_ready=1 → beats emerge in order, one per cycle; in_ready returns 1.
- Opcode 0x7F → out_illegal=1, wb_en=0, a=b=0. MUL 0x022081B3: illegal without RV32M_EN; with it, funct7 0x01, funct3 0, wb_en=1.
- flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- rst_n low asynchronously mid-stream → outputs zero and out_valid=0 immediately; in_ready=1. The first beat after release has latency 1.
